demorgan_sweep_checker: RTL and testbench
=========================================

Name: demorgan_sweep_checker

Overview:
- Self-checking stimulus stage that sits directly upstream of the two-input De Morgan gates and consumes their outputs.
- Drives every (a, b) combination into the NOR form and the AND-of-inverted form, waits for them to settle, and samples both results.
- Compares each result against the expected value ~(a|b), and reports an error count, the first failing vector and pass/fail.
- Lets the board-level lab prove both gate forms equivalent without a simulator.

Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before sampling; legal range >= 1.
- PASSES, 1: number of full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 8: width of err_count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- c_in  input  1  result from the NOR-form gate, ~(a|b).
- d_in  input  1  result from the inverted-AND-form gate, ~a & ~b.
- a_out  output  1  stimulus bit a (registered).
- b_out  output  1  stimulus bit b (registered).
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE state; held until the next start or rst.
- pass  output  1  done && err_count==0.
- err_count  output  ERR_W  number of failing vectors; saturates at all-ones.
- first_err_valid  output  1  at least one failure seen in this run.
- first_err_vec  output  2  {a,b} of the first failing vector.

Behaviour:
- Reset: the clock and reset ports are one clock, clk, and a synchronous active-high reset, rst.
  - On any edge with rst=1: state=IDLE.
  - All outputs 0: a_out, b_out, busy, done, pass, err_count, first_err_valid, first_err_vec.
  - Internal vector, settle and pass counters cleared.
  - rst has priority over start.
  - rst mid-run aborts immediately; no partial results are kept.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - a_out=b_out=0.
  - start=1 -> DRIVE; vec=00, settle=0, pass_idx=0, err_count/first_err_* cleared; busy=1 from the next cycle.
- DRIVE:
  - {a_out,b_out}=vec; settle increments each cycle.
  - After SETTLE_CYCLES cycles in DRIVE -> SAMPLE.
- SAMPLE: one cycle.
  - exp = ~(a_out|b_out).
  - Vector fails if c_in!=exp OR d_in!=exp; a double failure counts once.
  - On fail: err_count += 1, saturating at 2^ERR_W-1. If first_err_valid==0: first_err_vec=vec and first_err_valid=1.
  - Next state:
    - vec<3 -> vec+1, settle=0, DRIVE.
    - vec==3 and pass_idx<PASSES-1 -> vec=00, pass_idx+1, DRIVE.
    - Otherwise -> DONE.
- DONE:
  - busy=0, done=1; a_out=b_out=0.
  - pass and err_count hold.
  - start=1 -> same restart as from IDLE (counters cleared, done falls next cycle).
- start while busy is ignored.
- Vector order: 00, 01, 10, 11 with vec[1]=a, vec[0]=b.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - With start sampled at edge k, busy is high from edge k+1 through k+4*PASSES*(SETTLE_CYCLES+1).
  - done rises at edge k+1+4*PASSES*(SETTLE_CYCLES+1).
  - Defaults give a 12-cycle run, with done at k+13.
- c_in and d_in are sampled only in SAMPLE; glitches during DRIVE are irrelevant.
- Stimulus changes only on the DRIVE entry edge.

Test Plan:
- Ideal gates (c_in=d_in=~(a_out|b_out) combinationally), defaults, start pulse at edge k:
  - a/b sequence 00x3, 01x3, 10x3, 11x3.
  - busy high for 12 cycles; done=1 at k+13.
  - err_count=0, pass=1, first_err_valid=0.
- c_in stuck at 0, d_in ideal:
  - only vector 00 fails.
  - err_count=1, first_err_vec=00, first_err_valid=1, pass=0.
- d_in wired as ~(a&b) (wrong law):
  - vectors 01 and 10 fail.
  - err_count=2, first_err_vec=01.
- PASSES=3, ERR_W=3, d_in stuck at 1:
  - 3 failures per pass, 9 total -> err_count saturates at 7.
  - done at k+1+36 with SETTLE_CYCLES=2.
- Reset and ignored start:
  - start at k, rst asserted at k+5 -> at k+6 busy=0, a_out=b_out=0, err_count=0, state IDLE.
  - start held high during a run -> no restart; run length is still 12.
- Restart from DONE after a failing run:
  - start in DONE -> next cycle done=0, busy=1, err_count=0, first_err_valid=0.
  - Second run with ideal gates ends pass=1.

Source files
------------

// File: rtl/demorgan_sweep_checker.sv
// rtl/demorgan_sweep_checker.sv - sweeps all (a,b) vectors through two De Morgan gate forms and checks results
module demorgan_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c_in,
  input  logic             d_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        vec, vec_n;
  logic [SW-1:0]     settle, settle_n;
  logic [PW-1:0]     pass_idx, pass_idx_n;
  logic [ERR_W-1:0]  err_n;
  logic              fev_n;
  logic [1:0]        fvec_n;
  logic              run_n;
  logic              exp_bit;
  logic              vec_fail;

  // The expected value is derived from the registered stimulus, so it matches what the gates see.
  assign exp_bit  = ~(a_out | b_out);
  assign vec_fail = (c_in != exp_bit) || (d_in != exp_bit);
  assign run_n    = (state_n == DRIVE) || (state_n == SAMPLE);

  // Next-state and next-result logic; all registered outputs derive from these.
  always_comb begin
    state_n    = state;
    vec_n      = vec;
    settle_n   = settle;
    pass_idx_n = pass_idx;
    err_n      = err_count;
    fev_n      = first_err_valid;
    fvec_n     = first_err_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = DRIVE;
          vec_n      = 2'd0;
          settle_n   = '0;
          pass_idx_n = '0;
          err_n      = '0;
          fev_n      = 1'b0;
          fvec_n     = 2'd0;
        end
      end
      DRIVE: begin
        settle_n = settle + SW'(1);
        if (settle == SW'(SETTLE_CYCLES - 1)) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (vec_fail) begin
          if (err_count != '1) begin
            err_n = err_count + ERR_W'(1);
          end
          if (!first_err_valid) begin
            fev_n  = 1'b1;
            fvec_n = vec;
          end
        end
        if (vec != 2'd3) begin
          vec_n    = vec + 2'd1;
          settle_n = '0;
          state_n  = DRIVE;
        end else if (pass_idx != PW'(PASSES - 1)) begin
          vec_n      = 2'd0;
          pass_idx_n = pass_idx + PW'(1);
          settle_n   = '0;
          state_n    = DRIVE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset wins over everything and discards partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vec             <= 2'd0;
      settle          <= '0;
      pass_idx        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 2'd0;
      a_out           <= 1'b0;
      b_out           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      state           <= state_n;
      vec             <= vec_n;
      settle          <= settle_n;
      pass_idx        <= pass_idx_n;
      err_count       <= err_n;
      first_err_valid <= fev_n;
      first_err_vec   <= fvec_n;
      a_out           <= run_n & vec_n[1];
      b_out           <= run_n & vec_n[0];
      busy            <= run_n;
      done            <= (state_n == DONE);
      pass            <= (state_n == DONE) && (err_n == '0);
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// tb/tb_demorgan_sweep_checker.sv - directed self-checking bench for demorgan_sweep_checker
module tb_demorgan_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  int         mode = 0;

  logic       a1, b1, c1, d1, busy1, done1, pass1, fev1;
  logic [7:0] err1;
  logic [1:0] fvec1;

  logic       a2, b2, c2, d2, busy2, done2, pass2, fev2;
  logic [2:0] err2;
  logic [1:0] fvec2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Gate models for the default-parameter instance; mode selects the fault.
  always_comb begin
    c1 = ~(a1 | b1);
    d1 = ~a1 & ~b1;
    case (mode)
      1: c1 = 1'b0;
      2: d1 = ~(a1 & b1);
      default: ;
    endcase
  end

  // Gate models for the saturation instance: d stuck at 1.
  assign c2 = ~(a2 | b2);
  assign d2 = 1'b1;

  demorgan_sweep_checker dut1 (
    .clk(clk), .rst(rst), .start(start1), .c_in(c1), .d_in(d1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fev1), .first_err_vec(fvec1)
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .c_in(c2), .d_in(d2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_valid(fev2), .first_err_vec(fvec2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ab",    32'({a1, b1}), 32'd0);
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_done",  32'(done1), 32'd0);
    check("rst_pass",  32'(pass1), 32'd0);
    check("rst_err",   32'(err1), 32'd0);
    check("rst_fev",   32'(fev1), 32'd0);
    check("rst_fvec",  32'(fvec1), 32'd0);

    // Saturation instance: 3 passes, d stuck at 1, 3 fails per pass -> 9 saturates at 7
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 1; i < 36; i++) tick();
    check("sat_busy_last", 32'(busy2), 32'd1);
    check("sat_done_early", 32'(done2), 32'd0);
    tick();
    check("sat_done",  32'(done2), 32'd1);
    check("sat_busy",  32'(busy2), 32'd0);
    check("sat_err",   32'(err2), 32'd7);
    check("sat_fev",   32'(fev2), 32'd1);
    check("sat_fvec",  32'(fvec2), 32'd1);
    check("sat_pass",  32'(pass2), 32'd0);

    // Run 1: ideal gates, check stimulus sequence and busy window
    mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("r1_busy", 32'(busy1), 32'd1);
      check("r1_done", 32'(done1), 32'd0);
      check("r1_ab",   32'({a1, b1}), 32'(i / 3));
      tick();
    end
    check("r1_done_end", 32'(done1), 32'd1);
    check("r1_busy_end", 32'(busy1), 32'd0);
    check("r1_pass",     32'(pass1), 32'd1);
    check("r1_err",      32'(err1), 32'd0);
    check("r1_fev",      32'(fev1), 32'd0);
    check("r1_ab_end",   32'({a1, b1}), 32'd0);

    // Run 2: c stuck at 0 -> only vector 00 fails
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 1; i < 13; i++) tick();
    check("r2_done", 32'(done1), 32'd1);
    check("r2_err",  32'(err1), 32'd1);
    check("r2_fev",  32'(fev1), 32'd1);
    check("r2_fvec", 32'(fvec1), 32'd0);
    check("r2_pass", 32'(pass1), 32'd0);

    // Run 3: restart from a failing DONE, d wired as ~(a&b) -> vectors 01 and 10 fail
    mode = 2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("r3_done_clr", 32'(done1), 32'd0);
    check("r3_busy",     32'(busy1), 32'd1);
    check("r3_err_clr",  32'(err1), 32'd0);
    check("r3_fev_clr",  32'(fev1), 32'd0);
    for (int i = 1; i < 13; i++) tick();
    check("r3_done", 32'(done1), 32'd1);
    check("r3_err",  32'(err1), 32'd2);
    check("r3_fvec", 32'(fvec1), 32'd1);
    check("r3_pass", 32'(pass1), 32'd0);

    // Run 4: ideal gates, start held high through the run -> no restart, still 12 cycles
    mode = 0;
    start1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("r4_busy", 32'(busy1), 32'd1);
    end
    start1 = 1'b0;
    tick();
    check("r4_done", 32'(done1), 32'd1);
    check("r4_pass", 32'(pass1), 32'd1);
    check("r4_err",  32'(err1), 32'd0);

    // Reset mid-run: c stuck at 0 so an error is already counted when rst hits
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    check("mid_err_before", 32'(err1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(busy1), 32'd0);
    check("mid_ab",   32'({a1, b1}), 32'd0);
    check("mid_err",  32'(err1), 32'd0);
    check("mid_done", 32'(done1), 32'd0);
    check("mid_fev",  32'(fev1), 32'd0);
    tick();
    check("mid_idle", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
